mdu_ctrl: RTL and testbench
===========================

// Module: mdu_ctrl
// PURPOSE
//   Multi-cycle multiply/divide unit with HI/LO registers, sitting beside the E-stage ALU.
//   Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from E and sequences the operation.
//   Exports stall_md, which is ORed into the pipeline stall signal. It freezes D while an
//   MDU instruction in D would collide with an in-flight or starting operation.
// PARAMETERS
//   MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//   DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1); ignored when MDU_ITER_DIV_EN is defined
// PORTS
//   clk       in   1   single clock, rising edge
//   reset_n   in   1   synchronous, active-low reset
//   e_start   in   1   valid MDU instruction in E this cycle
//   e_op      in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO
//   e_rs      in   32  forwarded rs value
//   e_rt      in   32  forwarded rt value
//   d_is_md   in   1   instruction in D is any MDU op (from D-stage decode)
//   busy      out  1   multi-cycle operation in flight
//   stall_md  out  1   d_is_md & (busy | (e_start & e_op<=3))
//   md_out    out  32  e_op==6 ? hi : e_op==7 ? lo : 0 (combinational; feeds E result mux)
//   hi        out  32  HI register
//   lo        out  32  LO register
// BEHAVIOUR
//   Reset (reset_n==0 at posedge): state=IDLE, cnt=0, hi=0, lo=0, busy=0.
//     Any operation in flight is aborted and never written back.
//   FSM:
//     IDLE -> BUSY  on e_start & e_op<=3. Latch rs/rt/op; cnt = MULT_CYCLES-1 or DIV_CYCLES-1.
//     BUSY: cnt decrements each cycle. At cnt==0: write hi/lo, go to IDLE.
//   busy=1 from the cycle after start through the cycle hi/lo are written (registered).
//   Total: N busy cycles. Result is visible in hi/lo on cycle start+N+1.
//   Arithmetic:
//     MULT   {hi,lo} = $signed(rs) * $signed(rt), full 64 bits.
//     MULTU  {hi,lo} = rs * rt, unsigned.
//     DIV    lo = quotient truncated toward zero; hi = remainder, sign of dividend (rs).
//     DIVU   same, unsigned.
//     rt==0 on DIV/DIVU: full latency, busy asserted, hi/lo left unchanged.
//     0x80000000 / -1 (DIV): lo = 0x80000000, hi = 0.
//   MTHI/MTLO: hi/lo = rs at the next edge. Single cycle, busy stays 0, only legal when not busy.
//   MFHI/MFLO: combinational read of the current hi/lo. Never stalls when busy==0.
//   Simultaneous events:
//     e_start while busy: ignored. stall_md guarantees it cannot occur.
//     reset_n low on the same edge as the final BUSY cycle: reset wins, hi=lo=0.
//   stall_md is combinational. It is asserted in the start cycle so the following MDU op waits.
//   No other outputs are combinational.
// CONFIGURATION
//   MDU_ITER_DIV_EN defined:
//     DIV/DIVU use a radix-2 restoring divider on magnitudes, one quotient bit per cycle.
//     Latency is fixed at 33 busy cycles: 32 iterations + 1 sign fix-up. DIV_CYCLES is unused.
//     Divide-by-zero and overflow results exactly as above.
//   MDU_ITER_DIV_EN undefined:
//     Result is computed with Verilog / and % at start, held in a shadow register,
//     and committed after DIV_CYCLES.
// TESTING
//   1. MULT rs=0xFFFFFFFE(-2), rt=3 -> after 5 busy cycles hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//   2. MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//   3. DIV rs=-7, rt=2 -> lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1).
//      DIVU rs=7, rt=0 -> hi/lo unchanged, busy for full latency.
//   4. MULT start with d_is_md=1 -> stall_md=1 in the start cycle and all 5 busy cycles,
//      0 the cycle after busy falls. d_is_md=0 never stalls.
//   5. MTLO rs=0x1234 while idle -> lo=0x1234 next cycle, busy stays 0.
//      MFLO then gives md_out=0x1234.
//   6. reset_n=0 on the third busy cycle of DIV -> next cycle busy=0, hi=lo=0.
//      No late write-back afterwards.

Source files
------------

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide unit with HI/LO registers beside the E-stage ALU.
// Optional macro MDU_ITER_DIV_EN selects a 33-cycle radix-2 restoring divider.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        e_start,
  input  logic [2:0]  e_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        d_is_md,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] md_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [63:0] res_q, res_d;
  logic        wr_q, wr_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        start_md;
  logic [63:0] prod_s, prod_u;

`ifdef MDU_ITER_DIV_EN
  logic [31:0] dvs_q, dvs_d;
  logic        isdiv_q, isdiv_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic [31:0] mag_rs, mag_rt;
  logic [32:0] rem_sh, rem_sub;
  logic [31:0] quo_sh;
`else
  logic [31:0] dvs_safe;
  logic        ovf;
  logic [31:0] q_s, r_s, q_u, r_u;
`endif

  assign start_md = e_start & ~e_op[2];
  assign busy     = (state_q == S_BUSY);
  assign stall_md = d_is_md & (busy | start_md);
  assign hi       = hi_q;
  assign lo       = lo_q;

  // E-stage result mux source for MFHI/MFLO
  always_comb begin
    md_out = 32'h0;
    if (e_op == 3'd6) md_out = hi_q;
    else if (e_op == 3'd7) md_out = lo_q;
  end

  // Full 64-bit products, formed at start and held until commit
  always_comb begin
    prod_s = {{32{e_rs[31]}}, e_rs} * {{32{e_rt[31]}}, e_rt};
    prod_u = {32'h0, e_rs} * {32'h0, e_rt};
  end

`ifdef MDU_ITER_DIV_EN
  // Operand magnitudes and one restoring-division step
  always_comb begin
    mag_rs  = (~e_op[0] & e_rs[31]) ? -e_rs : e_rs;
    mag_rt  = (~e_op[0] & e_rt[31]) ? -e_rt : e_rt;
    rem_sh  = {res_q[63:32], res_q[31]};
    quo_sh  = {res_q[30:0], 1'b0};
    rem_sub = rem_sh - {1'b0, dvs_q};
  end
`else
  // Direct divide; zero divisor and signed overflow handled explicitly
  always_comb begin
    dvs_safe = (e_rt == 32'h0) ? 32'h1 : e_rt;
    ovf      = (e_rs == 32'h8000_0000) && (e_rt == 32'hFFFF_FFFF);
    q_u      = e_rs / dvs_safe;
    r_u      = e_rs % dvs_safe;
    if (ovf) begin
      q_s = 32'h8000_0000;
      r_s = 32'h0;
    end else begin
      q_s = $signed(e_rs) / $signed(dvs_safe);
      r_s = $signed(e_rs) % $signed(dvs_safe);
    end
  end
`endif

  // Next-state: start, count down, commit to HI/LO
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    wr_d    = wr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MDU_ITER_DIV_EN
    dvs_d   = dvs_q;
    isdiv_d = isdiv_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_md) begin
          state_d = S_BUSY;
          if (!e_op[1]) begin
            cnt_d = 8'(MULT_CYCLES - 1);
            res_d = e_op[0] ? prod_u : prod_s;
            wr_d  = 1'b1;
`ifdef MDU_ITER_DIV_EN
            isdiv_d = 1'b0;
`endif
          end else begin
            wr_d = (e_rt != 32'h0);
`ifdef MDU_ITER_DIV_EN
            cnt_d   = 8'd32;
            res_d   = {32'h0, mag_rs};
            dvs_d   = mag_rt;
            isdiv_d = 1'b1;
            negq_d  = ~e_op[0] & (e_rs[31] ^ e_rt[31]);
            negr_d  = ~e_op[0] & e_rs[31];
`else
            cnt_d = 8'(DIV_CYCLES - 1);
            res_d = e_op[0] ? {r_u, q_u} : {r_s, q_s};
`endif
          end
        end else if (e_start && e_op == 3'd4) begin
          hi_d = e_rs;
        end else if (e_start && e_op == 3'd5) begin
          lo_d = e_rs;
        end
      end
      S_BUSY: begin
        if (cnt_q == 8'd0) begin
          state_d = S_IDLE;
          if (wr_q) begin
`ifdef MDU_ITER_DIV_EN
            if (isdiv_q) begin
              hi_d = negr_q ? -res_q[63:32] : res_q[63:32];
              lo_d = negq_q ? -res_q[31:0] : res_q[31:0];
            end else begin
              hi_d = res_q[63:32];
              lo_d = res_q[31:0];
            end
`else
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
`endif
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
`ifdef MDU_ITER_DIV_EN
          if (isdiv_q) begin
            if (rem_sh >= {1'b0, dvs_q})
              res_d = {rem_sub[31:0], quo_sh | 32'h1};
            else
              res_d = {rem_sh[31:0], quo_sh};
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any in-flight operation
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      res_q   <= 64'h0;
      wr_q    <= 1'b0;
      hi_q    <= 32'h0;
      lo_q    <= 32'h0;
`ifdef MDU_ITER_DIV_EN
      dvs_q   <= 32'h0;
      isdiv_q <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      wr_q    <= wr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MDU_ITER_DIV_EN
      dvs_q   <= dvs_d;
      isdiv_q <= isdiv_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
`endif
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl.
// Divide latency follows MDU_ITER_DIV_EN.
module tb_mdu_ctrl;

`ifdef MDU_ITER_DIV_EN
  localparam int DIVN = 33;
`else
  localparam int DIVN = 10;
`endif
  localparam int MULN = 5;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        e_start;
  logic [2:0]  e_op;
  logic [31:0] e_rs;
  logic [31:0] e_rt;
  logic        d_is_md;
  logic        busy;
  logic        stall_md;
  logic [31:0] md_out;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .e_start(e_start), .e_op(e_op),
    .e_rs(e_rs), .e_rt(e_rt), .d_is_md(d_is_md), .busy(busy),
    .stall_md(stall_md), .md_out(md_out), .hi(hi), .lo(lo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] rs,
                       input logic [31:0] rt);
    e_start = 1'b1;
    e_op    = op;
    e_rs    = rs;
    e_rt    = rt;
    tick();
    e_start = 1'b0;
    e_op    = 3'd0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    e_start = 1'b0;
    e_op    = 3'd0;
    e_rs    = 32'h0;
    e_rt    = 32'h0;
    d_is_md = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    tests_run++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || stall_md !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset: busy=%b hi=%h lo=%h stall=%b want 0/0/0/0",
               busy, hi, lo, stall_md);
    end
  endtask

  task automatic test_mult();
    int n;
    int bad;
    d_is_md = 1'b1;
    e_start = 1'b1;
    e_op    = 3'd0;
    e_rs    = 32'hFFFF_FFFE;
    e_rt    = 32'd3;
    #1;
    tests_run++;
    if (stall_md !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL mult_start_stall: stall=%b busy=%b want 1/0", stall_md, busy);
    end
    tick();
    e_start = 1'b0;
    n = 0;
    bad = 0;
    while (busy === 1'b1 && n < 100) begin
      if (stall_md !== 1'b1) bad++;
      n++;
      tick();
    end
    tests_run++;
    if (bad != 0 || n != MULN) begin
      tests_failed++;
      $display("FAIL mult_busy: cycles=%0d stall_gaps=%0d want %0d/0", n, bad, MULN);
    end
    tests_run++;
    if (stall_md !== 1'b0 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      tests_failed++;
      $display("FAIL mult_result: stall=%b hi=%h lo=%h want 0 ffffffff fffffffa",
               stall_md, hi, lo);
    end
  endtask

  task automatic test_multu();
    int n;
    int bad;
    d_is_md = 1'b0;
    e_start = 1'b1;
    e_op    = 3'd1;
    e_rs    = 32'hFFFF_FFFF;
    e_rt    = 32'hFFFF_FFFF;
    #1;
    bad = (stall_md !== 1'b0) ? 1 : 0;
    tick();
    e_start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      if (stall_md !== 1'b0) bad++;
      n++;
      tick();
    end
    tests_run++;
    if (bad != 0 || n != MULN) begin
      tests_failed++;
      $display("FAIL multu_nostall: cycles=%0d stalls=%0d want %0d/0", n, bad, MULN);
    end
    tests_run++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      tests_failed++;
      $display("FAIL multu_result: hi=%h lo=%h want fffffffe 00000001", hi, lo);
    end
  endtask

  task automatic test_div();
    int n;
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    tests_run++;
    if (n != DIVN || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("FAIL div_neg7_2: n=%0d hi=%h lo=%h want %0d ffffffff fffffffd",
               n, hi, lo, DIVN);
    end
    issue(3'd2, 32'd7, 32'hFFFF_FFFE);
    wait_idle(n);
    tests_run++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'h0000_0001) begin
      tests_failed++;
      $display("FAIL div_7_neg2: hi=%h lo=%h want 00000001 fffffffd", hi, lo);
    end
    issue(3'd3, 32'hFFFF_FFFF, 32'h10);
    wait_idle(n);
    tests_run++;
    if (lo !== 32'h0FFF_FFFF || hi !== 32'h0000_000F) begin
      tests_failed++;
      $display("FAIL divu_big: hi=%h lo=%h want 0000000f 0fffffff", hi, lo);
    end
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    tests_run++;
    if (lo !== 32'h8000_0000 || hi !== 32'h0) begin
      tests_failed++;
      $display("FAIL div_ovf: hi=%h lo=%h want 00000000 80000000", hi, lo);
    end
  endtask

  task automatic test_divu_zero();
    int n;
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    issue(3'd3, 32'd7, 32'd0);
    wait_idle(n);
    tests_run++;
    if (n != DIVN || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      tests_failed++;
      $display("FAIL divu_zero: n=%0d hi=%h lo=%h want %0d ffffffff fffffffd",
               n, hi, lo, DIVN);
    end
  endtask

  task automatic test_mtlo_mflo();
    d_is_md = 1'b1;
    e_start = 1'b1;
    e_op    = 3'd5;
    e_rs    = 32'h1234;
    #1;
    tests_run++;
    if (stall_md !== 1'b0) begin
      tests_failed++;
      $display("FAIL mtlo_stall: stall=%b want 0", stall_md);
    end
    tick();
    tests_run++;
    if (lo !== 32'h1234 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL mtlo: lo=%h busy=%b want 00001234/0", lo, busy);
    end
    e_op = 3'd4;
    e_rs = 32'hABCD;
    tick();
    e_op = 3'd7;
    #1;
    tests_run++;
    if (md_out !== 32'h1234) begin
      tests_failed++;
      $display("FAIL mflo: md_out=%h want 00001234", md_out);
    end
    e_op = 3'd6;
    #1;
    tests_run++;
    if (md_out !== 32'hABCD || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL mfhi: md_out=%h busy=%b want 0000abcd/0", md_out, busy);
    end
    e_start = 1'b0;
    e_op    = 3'd0;
    #1;
    tests_run++;
    if (md_out !== 32'h0) begin
      tests_failed++;
      $display("FAIL md_out_idle: md_out=%h want 0", md_out);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    issue(3'd0, 32'd2, 32'd3);
    tick();
    issue(3'd4, 32'hDEAD, 32'd0);
    wait_idle(n);
    tests_run++;
    if (hi !== 32'h0 || lo !== 32'h6 || n != MULN - 2) begin
      tests_failed++;
      $display("FAIL start_while_busy: hi=%h lo=%h n=%0d want 0 6 %0d",
               hi, lo, n, MULN - 2);
    end
  endtask

  task automatic test_reset_mid_div();
    int bad;
    issue(3'd3, 32'd100, 32'd7);
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tests_run++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_div: busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
    end
    bad = 0;
    for (int i = 0; i < DIVN + 5; i++) begin
      tick();
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL late_writeback: bad_cycles=%0d want 0 (hi=%h lo=%h)", bad, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_divu_zero();
    test_mtlo_mflo();
    test_back_to_back();
    test_mtlo_mflo();
    test_reset_mid_div();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
